// File: rtl/rename_dispatch_queue.sv
// In-order rename-to-dispatch FIFO with operand capture, CDB wakeup
// and lowest-free reservation-station grant for ALU and branch classes.
module rename_dispatch_queue #(
    parameter int WIDTH = 32,
    parameter int ROB   = 3,
    parameter int N_ALU = 4,
    parameter int N_BR  = 2,
    parameter int DEPTH = 2,
    parameter int CTRL  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_is_jal,
    input  logic             in_is_branch,
    input  logic [CTRL-1:0]  in_ctrl,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic             in_busy1,
    input  logic             in_busy2,
    input  logic [ROB-1:0]   in_tag1,
    input  logic [ROB-1:0]   in_tag2,
    input  logic [WIDTH:0]   in_robval1,
    input  logic [WIDTH:0]   in_robval2,
    input  logic             cdb_valid,
    input  logic [ROB-1:0]   cdb_tag,
    input  logic [WIDTH-1:0] cdb_value,
    input  logic             flush,
    input  logic [N_ALU-1:0] alu_busy,
    input  logic [N_BR-1:0]  br_busy,
    output logic [N_ALU-1:0] alu_req,
    output logic [N_BR-1:0]  br_req,
    output logic [WIDTH-1:0] dsp_value1,
    output logic [WIDTH-1:0] dsp_value2,
    output logic             dsp_ready1,
    output logic             dsp_ready2,
    output logic [ROB-1:0]   dsp_tag1,
    output logic [ROB-1:0]   dsp_tag2,
    output logic [CTRL-1:0]  dsp_ctrl,
    output logic [WIDTH-1:0] dsp_target,
    output logic [WIDTH-1:0] dsp_seqpc,
    output logic             dsp_jump,
    output logic             alu_full,
    output logic             br_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] v;
        logic             r;
        logic [ROB-1:0]   t;
    } opnd_t;

    typedef struct packed {
        logic             valid;
        logic             is_br;
        logic             jump;
        logic [CTRL-1:0]  ctrl;
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] seqpc;
        opnd_t            o1;
        opnd_t            o2;
    } entry_t;

    entry_t [DEPTH-1:0] q_q, q_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    entry_t           head;
    entry_t           new_e;
    logic [N_ALU-1:0] alu_free;
    logic [N_BR-1:0]  br_free;
    logic             push, pop;

    function automatic opnd_t resolve(
        input logic             busy,
        input logic [WIDTH-1:0] op,
        input logic [ROB-1:0]   tag,
        input logic [WIDTH:0]   rv,
        input logic             cv,
        input logic [ROB-1:0]   ct,
        input logic [WIDTH-1:0] cval
    );
        opnd_t o;
        o.t = tag;
        o.v = '0;
        o.r = 1'b0;
        if (!busy) begin
            o.v = op;
            o.r = 1'b1;
        end else if (rv[WIDTH]) begin
            o.v = rv[WIDTH-1:0];
            o.r = 1'b1;
        end else if (cv && ct == tag) begin
            o.v = cval;
            o.r = 1'b1;
        end
        return o;
    endfunction

    always_comb begin
        head     = q_q[head_q];
        alu_free = ~alu_busy & (alu_busy + N_ALU'(1));
        br_free  = ~br_busy & (br_busy + N_BR'(1));
        alu_req  = '0;
        br_req   = '0;
        if (head.valid && !flush) begin
            if (head.is_br) br_req = br_free;
            else            alu_req = alu_free;
        end
        pop      = |alu_req | |br_req;
        in_ready = !reset_n || (count_q < CW'(DEPTH) && !flush);
        push     = in_valid && in_ready;
        alu_full = &alu_busy;
        br_full  = &br_busy;
    end

    always_comb begin
        dsp_value1 = head.o1.v;
        dsp_value2 = head.o2.v;
        dsp_ready1 = head.o1.r;
        dsp_ready2 = head.o2.r;
        dsp_tag1   = head.o1.t;
        dsp_tag2   = head.o2.t;
        dsp_ctrl   = head.ctrl;
        dsp_target = head.target;
        dsp_seqpc  = head.seqpc;
        dsp_jump   = head.jump;
    end

    always_comb begin
        new_e.valid  = 1'b1;
        new_e.is_br  = in_is_branch;
        new_e.jump   = in_is_jal;
        new_e.ctrl   = in_ctrl;
        new_e.target = in_pc + in_imm;
        new_e.seqpc  = in_pc + WIDTH'(4);
        new_e.o1 = resolve(in_busy1, in_op1, in_tag1, in_robval1,
                           cdb_valid, cdb_tag, cdb_value);
        new_e.o2 = resolve(in_busy2, in_op2, in_tag2, in_robval2,
                           cdb_valid, cdb_tag, cdb_value);
    end

    always_comb begin
        q_d     = q_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            if (q_q[i].valid && cdb_valid) begin
                if (!q_q[i].o1.r && q_q[i].o1.t == cdb_tag) begin
                    q_d[i].o1.v = cdb_value;
                    q_d[i].o1.r = 1'b1;
                end
                if (!q_q[i].o2.r && q_q[i].o2.t == cdb_tag) begin
                    q_d[i].o2.v = cdb_value;
                    q_d[i].o2.r = 1'b1;
                end
            end
        end
        if (pop) begin
            q_d[head_q].valid = 1'b0;
            head_d = head_q + PW'(1);
        end
        if (push) begin
            q_d[tail_q] = new_e;
            tail_d = tail_q + PW'(1);
        end
        // Redirect discards everything, including this cycle's offer.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) q_d[i].valid = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q     <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
